cycle_window_ctrl: RTL and testbench

- Measurement controller directly upstream/downstream of the free-running 32-bit cycle counter: drives the counter's enable and consumes its count value.
- Opens a measurement window on a start pulse and closes it on a stop pulse or a timeout.
- Reports elapsed cycles, computed as a modulo-2^WIDTH snapshot difference, through a valid/ready result port.
- Sits between processor control (program start/halt) and the perf/debug readout logic.

---
 rtl/perf_pkg.sv | 14 +
 rtl/cycle_window_ctrl.sv | 117 +++++++++++
 tb/tb_cycle_window_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance/debug measurement blocks.
package perf_pkg;

  // Default counter width, matching the free-running cycle counter.
  localparam int unsigned CNT_WIDTH = 32;

  // Window controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } win_state_t;

endpackage : perf_pkg

// File: rtl/cycle_window_ctrl.sv
// Cycle window controller: opens a measurement window on start, closes it on
// stop or timeout, and reports the elapsed cycle count (modulo 2^WIDTH) via a
// valid/ready result port. It also drives the cycle counter's enable.
module cycle_window_ctrl
  import perf_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT_WIDTH,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_enable,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             result_wrap,
  output logic             result_timeout
);

  localparam logic [WIDTH-1:0] TIMEOUT_W  = WIDTH'(TIMEOUT);
  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

  win_state_t       r_state;
  logic [WIDTH-1:0] r_start_snap;
  logic [WIDTH-1:0] r_prev_delta;
  logic             r_wrap_sticky;

  logic             r_cnt_enable;
  logic             r_busy;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;
  logic             r_result_wrap;
  logic             r_result_timeout;

  logic [WIDTH-1:0] w_delta;
  logic             w_wrap_now;
  logic             w_timeout_hit;
  logic             w_close;

  // Elapsed count, wrap detection and close condition for the open window.
  always_comb begin
    w_delta       = count_in - r_start_snap;
    w_wrap_now    = (w_delta < r_prev_delta);
    w_timeout_hit = TIMEOUT_EN && (w_delta >= TIMEOUT_W);
    w_close       = stop || w_timeout_hit;
  end

  // Window state machine with registered outputs; reset abandons any window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_start_snap     <= '0;
      r_prev_delta     <= '0;
      r_wrap_sticky    <= 1'b0;
      r_cnt_enable     <= 1'b0;
      r_busy           <= 1'b0;
      r_result         <= '0;
      r_result_valid   <= 1'b0;
      r_result_wrap    <= 1'b0;
      r_result_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // start wins over a simultaneous stop; a lone stop is ignored
          if (start) begin
            r_start_snap  <= count_in;
            r_prev_delta  <= '0;
            r_wrap_sticky <= 1'b0;
            r_cnt_enable  <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= RUN;
          end
        end

        RUN: begin
          r_prev_delta <= w_delta;
          if (w_wrap_now) begin
            r_wrap_sticky <= 1'b1;
          end
          // start is ignored here; stop wins when both arrive together
          if (w_close) begin
            r_result         <= w_delta;
            r_result_timeout <= !stop;
            r_result_wrap    <= r_wrap_sticky | w_wrap_now;
            r_result_valid   <= 1'b1;
            r_busy           <= 1'b0;
            r_state          <= REPORT;
          end
        end

        REPORT: begin
          // result fields hold until drained; start/stop are ignored
          if (r_result_valid && result_ready) begin
            r_result_valid <= 1'b0;
            r_state        <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cnt_enable     = r_cnt_enable;
  assign busy           = r_busy;
  assign result         = r_result;
  assign result_valid   = r_result_valid;
  assign result_wrap    = r_result_wrap;
  assign result_timeout = r_result_timeout;

endmodule : cycle_window_ctrl

// File: tb/tb_cycle_window_ctrl.sv
// Directed testbench for cycle_window_ctrl: one DUT with timeout disabled and
// one with TIMEOUT=10, each with hand-computed expected results.
module tb_cycle_window_ctrl;

  logic        clk;
  logic        reset;

  // DUT A: TIMEOUT disabled
  logic        start, stop, result_ready;
  logic [31:0] count_in;
  logic        cnt_enable, busy, result_valid, result_wrap, result_timeout;
  logic [31:0] result;

  // DUT B: TIMEOUT = 10
  logic        t_start, t_stop, t_ready;
  logic [31:0] t_count;
  logic        t_cnt_enable, t_busy, t_valid, t_wrap, t_timeout;
  logic [31:0] t_result;

  int total;
  int bad;

  cycle_window_ctrl #(.WIDTH(32), .TIMEOUT(0)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .count_in       (count_in),
    .cnt_enable     (cnt_enable),
    .busy           (busy),
    .result         (result),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_wrap    (result_wrap),
    .result_timeout (result_timeout)
  );

  cycle_window_ctrl #(.WIDTH(32), .TIMEOUT(10)) u_dut_to (
    .clk            (clk),
    .reset          (reset),
    .start          (t_start),
    .stop           (t_stop),
    .count_in       (t_count),
    .cnt_enable     (t_cnt_enable),
    .busy           (t_busy),
    .result         (t_result),
    .result_valid   (t_valid),
    .result_ready   (t_ready),
    .result_wrap    (t_wrap),
    .result_timeout (t_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    total++;
    if ({cnt_enable, busy, result_valid, result_wrap, result_timeout} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00000",
               {cnt_enable, busy, result_valid, result_wrap, result_timeout});
    end
    total++;
    if (result !== 32'd0) begin
      bad++;
      $display("FAIL reset_result got=%0d exp=0", result);
    end
    total++;
    if ({t_cnt_enable, t_busy, t_valid, t_wrap, t_timeout} !== 5'b0 || t_result !== 32'd0) begin
      bad++;
      $display("FAIL reset_to_dut got=%b/%0d exp=00000/0",
               {t_cnt_enable, t_busy, t_valid, t_wrap, t_timeout}, t_result);
    end
    reset = 1'b1;
    step();
    total++;
    if (busy !== 1'b0 || cnt_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_release busy=%b en=%b exp=0/0", busy, cnt_enable);
    end
  endtask

  task automatic test_basic();
    count_in = 32'd100;
    start    = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || cnt_enable !== 1'b1 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_open busy=%b en=%b valid=%b exp=1/1/0", busy, cnt_enable, result_valid);
    end
    for (int i = 1; i <= 48; i++) begin
      count_in = 32'd100 + 32'(i);
      step();
    end
    count_in = 32'd149;
    stop     = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if (result !== 32'd49 || result_valid !== 1'b1 || result_wrap !== 1'b0 ||
        result_timeout !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_close res=%0d v=%b w=%b t=%b busy=%b exp=49/1/0/0/0",
               result, result_valid, result_wrap, result_timeout, busy);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    total++;
    if (result_valid !== 1'b0 || result !== 32'd49 || cnt_enable !== 1'b1) begin
      bad++;
      $display("FAIL basic_drain v=%b res=%0d en=%b exp=0/49/1", result_valid, result, cnt_enable);
    end
  endtask

  task automatic test_wraparound();
    count_in = 32'hFFFF_FFF0;
    start    = 1'b1;
    step();
    start    = 1'b0;
    count_in = 32'hFFFF_FFF8;
    step();
    count_in = 32'h0000_0010;
    stop     = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if (result !== 32'h20 || result_valid !== 1'b1 || result_wrap !== 1'b0) begin
      bad++;
      $display("FAIL wraparound res=%h v=%b w=%b exp=00000020/1/0", result, result_valid, result_wrap);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic test_full_wrap();
    // wrap seen in an earlier RUN cycle
    count_in = 32'd0;
    start    = 1'b1;
    step();
    start    = 1'b0;
    count_in = 32'hFFFF_FFFF;
    step();
    count_in = 32'd1;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if (result !== 32'd1 || result_wrap !== 1'b1 || result_timeout !== 1'b0) begin
      bad++;
      $display("FAIL full_wrap res=%0d w=%b t=%b exp=1/1/0", result, result_wrap, result_timeout);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    // wrap seen in the close cycle itself
    count_in = 32'd0;
    start    = 1'b1;
    step();
    start    = 1'b0;
    count_in = 32'hFFFF_FFFF;
    step();
    count_in = 32'd2;
    stop     = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if (result !== 32'd2 || result_wrap !== 1'b1) begin
      bad++;
      $display("FAIL wrap_in_close res=%0d w=%b exp=2/1", result, result_wrap);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    // sticky wrap must be cleared by the next window
    count_in = 32'd10;
    start    = 1'b1;
    step();
    start    = 1'b0;
    count_in = 32'd13;
    stop     = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if (result !== 32'd3 || result_wrap !== 1'b0) begin
      bad++;
      $display("FAIL wrap_cleared res=%0d w=%b exp=3/0", result, result_wrap);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic test_zero_length();
    count_in = 32'd500;
    start    = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if (result !== 32'd0 || result_valid !== 1'b1) begin
      bad++;
      $display("FAIL zero_length res=%0d v=%b exp=0/1", result, result_valid);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic test_timeout();
    t_count = 32'd5;
    t_start = 1'b1;
    step();
    t_start = 1'b0;
    for (int i = 6; i <= 14; i++) begin
      t_count = 32'(i);
      step();
    end
    total++;
    if (t_busy !== 1'b1 || t_valid !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early busy=%b v=%b exp=1/0", t_busy, t_valid);
    end
    t_count = 32'd15;
    step();
    total++;
    if (t_result !== 32'd10 || t_valid !== 1'b1 || t_timeout !== 1'b1 || t_busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_close res=%0d v=%b t=%b busy=%b exp=10/1/1/0",
               t_result, t_valid, t_timeout, t_busy);
    end
    t_ready = 1'b1;
    step();
    t_ready = 1'b0;
    // stop in the timeout cycle: closed by stop, not timeout
    t_count = 32'd20;
    t_start = 1'b1;
    step();
    t_start = 1'b0;
    for (int i = 21; i <= 29; i++) begin
      t_count = 32'(i);
      step();
    end
    t_count = 32'd30;
    t_stop  = 1'b1;
    step();
    t_stop = 1'b0;
    total++;
    if (t_result !== 32'd10 || t_valid !== 1'b1 || t_timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_with_stop res=%0d v=%b t=%b exp=10/1/0", t_result, t_valid, t_timeout);
    end
    t_ready = 1'b1;
    step();
    t_ready = 1'b0;
  endtask

  task automatic test_collisions();
    // lone stop in IDLE is ignored
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL stop_in_idle busy=%b v=%b exp=0/0", busy, result_valid);
    end
    // start+stop in IDLE opens the window
    count_in = 32'd1000;
    start    = 1'b1;
    stop     = 1'b1;
    step();
    total++;
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_start_stop busy=%b v=%b exp=1/0", busy, result_valid);
    end
    // start+stop in RUN closes the window
    count_in = 32'd1007;
    step();
    start = 1'b0;
    stop  = 1'b0;
    total++;
    if (busy !== 1'b0 || result_valid !== 1'b1 || result !== 32'd7 || result_timeout !== 1'b0) begin
      bad++;
      $display("FAIL run_start_stop busy=%b v=%b res=%0d t=%b exp=0/1/7/0",
               busy, result_valid, result, result_timeout);
    end
    // start/stop in REPORT with ready low are ignored
    for (int i = 0; i < 5; i++) begin
      start    = 1'b1;
      stop     = (i == 2);
      count_in = 32'd2000 + 32'(i);
      step();
    end
    start = 1'b0;
    stop  = 1'b0;
    total++;
    if (result_valid !== 1'b1 || result !== 32'd7 || busy !== 1'b0) begin
      bad++;
      $display("FAIL report_hold v=%b res=%0d busy=%b exp=1/7/0", result_valid, result, busy);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    total++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL report_drain v=%b busy=%b exp=0/0", result_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    count_in = 32'd3000;
    start    = 1'b1;
    step();
    start    = 1'b0;
    count_in = 32'd3005;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    total++;
    if (busy !== 1'b0 || cnt_enable !== 1'b0 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run busy=%b en=%b v=%b exp=0/0/0", busy, cnt_enable, result_valid);
    end
    // state returned to IDLE: a stop must not produce a report
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0) begin
      bad++;
      $display("FAIL no_report_after_reset v=%b busy=%b res=%0d exp=0/0/0", result_valid, busy, result);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    result_ready = 1'b0;
    count_in     = '0;
    t_start      = 1'b0;
    t_stop       = 1'b0;
    t_ready      = 1'b0;
    t_count      = '0;

    test_reset();
    test_basic();
    test_wraparound();
    test_full_wrap();
    test_zero_length();
    test_timeout();
    test_collisions();
    test_reset_mid_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cycle_window_ctrl
